sda_axi_fifo_buffer: RTL
========================

// Module: sda_axi_fifo_buffer
// PURPOSE
//  Parametrised SELF-to-AXI channel buffer, successor to the single-stage AXI output buffers.
//  Accepts words on a SELF valid/stop interface and presents them on an AXI valid/ready
//  interface through a Depth-entry first-word-fall-through FIFO.
//  Sits between generated kernel logic and one m_axi_gmem channel (AR, AW or W), giving
//  burst-rate decoupling in place of single-register buffering.
// PARAMETERS
//  DataWidth        64  width of the concatenated channel bus, in bits (>=1)
//  Depth            4   FIFO entries; power of two, >=2
//  AlmostFullLevel  3   level at/above which almost_full is asserted (1..Depth)
// PORTS
//  ap_clk       in   1                     clock; all state updates on its rising edge
//  ap_rst_n     in   1                     reset, synchronous, active-low
//  in_valid     in   1                     SELF producer word valid
//  in_data      in   DataWidth             SELF producer word
//  in_stop      out  1                     SELF backpressure; 1 = word not accepted
//  out_valid    out  1                     AXI valid
//  out_data     out  DataWidth             AXI payload
//  out_ready    in   1                     AXI ready from the interconnect
//  buf_level    out  $clog2(Depth+1)       occupancy (SDA_AXI_BUF_LEVEL_EN only)
//  almost_full  out  1                     buf_level >= AlmostFullLevel (SDA_AXI_BUF_LEVEL_EN only)
// BEHAVIOUR
//  - Reset (ap_rst_n=0 at a clock edge): rd_ptr=wr_ptr=count=0; out_valid=0; in_stop=0;
//    buf_level=0; almost_full=0. Storage contents are not reset; they are don't-care.
//  - Reset mid-operation flushes all held words. No partial transfer is completed.
//    out_valid is 0 from the first edge at which reset is sampled.
//  - Push: in_valid && !in_stop. Pop: out_valid && out_ready.
//  - in_stop = (count==Depth). It is decoded from the count register only, with no
//    combinational path from in_valid or out_ready.
//  - out_valid = (count!=0). out_data = mem[rd_ptr], so the head word falls through.
//  - Latency: a word pushed at edge N is visible on out_valid/out_data after edge N,
//    i.e. 1 cycle. Zero-cycle pass-through is not supported.
//  - AXI rule: once out_valid=1 it stays 1 and out_data stays stable until a pop.
//    out_valid never depends on out_ready.
//  - Count update per edge:
//    - push only: +1
//    - pop only: -1
//    - push and pop together: unchanged, both pointers advance
//    - neither: unchanged
//  - Full (count==Depth): in_stop=1 and no push occurs. A pop in that cycle frees a slot;
//    in_stop drops the following cycle.
//  - Empty (count==0): no pop is possible (out_valid=0). A push in that cycle makes
//    count=1.
//  - Pointers are $clog2(Depth) bits and wrap modulo Depth naturally. count is
//    $clog2(Depth+1) bits and never exceeds Depth or goes below 0.
//  - Words leave in strict arrival order. No word is dropped or duplicated.
//  - in_data is sampled only on a push edge. Values of in_data while in_valid=0 are ignored.
//  - Elaboration: Depth that is not a power of two, or AlmostFullLevel outside
//    1..Depth, triggers $error in simulation.
// CONFIGURATION
//  - SDA_AXI_BUF_LEVEL_EN defined: ports buf_level and almost_full exist.
//    - buf_level = count register.
//    - almost_full is registered, updated on the same edge as count, and reset to 0.
//  - SDA_AXI_BUF_LEVEL_EN undefined: neither port exists and no comparator is built.
//    All other behaviour is identical.
// TESTING  (DataWidth=8, Depth=4, AlmostFullLevel=3, SDA_AXI_BUF_LEVEL_EN defined)
//  1. ap_rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, in_stop=0, buf_level=0,
//     almost_full=0 throughout.
//  2. Push 0xA5 with out_ready=1 -> next cycle out_valid=1, out_data=0xA5. Popped that
//     cycle; the cycle after, out_valid=0 and buf_level=0.
//  3. out_ready=0, push 0x01..0x05 on consecutive cycles:
//     - almost_full=1 after the 3rd push; in_stop=1 after the 4th.
//     - 0x05 is held by the producer.
//     - Then out_ready=1 -> 0x01,0x02,0x03,0x04,0x05 are emitted in order.
//  4. Level 2 (0x10,0x11 held), push 0x12 and pop in the same cycle -> buf_level stays 2.
//     Outputs: 0x10 now, then 0x11, then 0x12.
//  5. Level 3, assert ap_rst_n=0 for 1 cycle -> next cycle out_valid=0, buf_level=0.
//     A push of 0x77 after reset is the first word out.
//  6. out_valid=1 with out_ready=0 for 10 cycles while the producer keeps pushing ->
//     out_data remains the head word and out_valid remains 1. Assertion checks no
//     change before the pop.

Source files
------------

// File: rtl/sda_axi_fifo_buffer.sv
// SELF valid/stop to AXI valid/ready channel buffer: Depth-entry first-word-fall-through FIFO.
// Optional occupancy ports buf_level/almost_full are built when SDA_AXI_BUF_LEVEL_EN is defined.
module sda_axi_fifo_buffer #(
  parameter int DataWidth       = 64,
  parameter int Depth           = 4,
  parameter int AlmostFullLevel = 3
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         in_valid,
  input  logic [DataWidth-1:0]         in_data,
  output logic                         in_stop,
  output logic                         out_valid,
  output logic [DataWidth-1:0]         out_data,
  input  logic                         out_ready
`ifdef SDA_AXI_BUF_LEVEL_EN
  ,
  output logic [$clog2(Depth+1)-1:0]   buf_level,
  output logic                         almost_full
`endif
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = $clog2(Depth+1);
  localparam logic [CntW-1:0] CntFull = CntW'(Depth);

  if ((Depth < 2) || ((Depth & (Depth - 1)) != 0)) begin : g_bad_depth
    $error("sda_axi_fifo_buffer: Depth must be a power of two >= 2");
  end
  if ((AlmostFullLevel < 1) || (AlmostFullLevel > Depth)) begin : g_bad_afl
    $error("sda_axi_fifo_buffer: AlmostFullLevel must lie in 1..Depth");
  end

  logic [DataWidth-1:0] mem [Depth];
  logic [PtrW-1:0]      rd_ptr;
  logic [PtrW-1:0]      wr_ptr;
  logic [CntW-1:0]      count;
  logic [CntW-1:0]      count_nxt;
  logic                 push;
  logic                 pop;

  // Handshake flags come from the count register only, so no input-to-output path exists.
  assign in_stop   = (count == CntFull);
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];

  assign push = in_valid && !in_stop;
  assign pop  = out_valid && out_ready;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge ap_clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

`ifdef SDA_AXI_BUF_LEVEL_EN
  localparam logic [CntW-1:0] AfLevel = CntW'(AlmostFullLevel);

  assign buf_level = count;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      almost_full <= 1'b0;
    end else begin
      almost_full <= (count_nxt >= AfLevel);
    end
  end
`endif

endmodule
